// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the pipeline controller and the HI/LO multiply-divide unit.
// The controller drives the master side and the unit implements the slave side.
interface hilo_muldiv_unit_if;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        cancel;
  logic        busy;
  logic        register_hi_write_enable;
  logic [31:0] register_hi_write_data;
  logic        register_lo_write_enable;
  logic [31:0] register_lo_write_data;

  modport master (
    output start, operation, operand_a, operand_b, cancel,
    input  busy, register_hi_write_enable, register_hi_write_data,
           register_lo_write_enable, register_lo_write_data
  );

  modport slave (
    input  start, operation, operand_a, operand_b, cancel,
    output busy, register_hi_write_enable, register_hi_write_data,
           register_lo_write_enable, register_lo_write_data
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO producer: single-cycle MTHI/MTLO, two-cycle MULT/MULTU and a restoring
// divider for DIV/DIVU, all with registered write pulses and a flush cancel.
module hilo_muldiv_unit #(
  parameter int unsigned DIV_ITERATIONS = 32
) (
  input logic                clock,
  input logic                reset,
  hilo_muldiv_unit_if.slave  bus_io
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StMul    = 2'd1;
  localparam logic [1:0] StDiv    = 2'd2;
  localparam logic [1:0] StDivFix = 2'd3;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;      // multiplicand, or dividend shifting into quotient
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        mul_signed_q, mul_signed_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div_zero_q, div_zero_d;
  logic        busy_q, busy_d;
  logic        hi_we_q, hi_we_d;
  logic        lo_we_q, lo_we_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic [31:0] lo_data_q, lo_data_d;

  logic [63:0] mul_a, mul_b, product;
  logic [32:0] shifted;
  logic [31:0] trial;
  logic        fits;
  logic        op_signed;

  assign mul_a   = {{32{mul_signed_q & a_q[31]}}, a_q};
  assign mul_b   = {{32{mul_signed_q & b_q[31]}}, b_q};
  assign product = mul_a * mul_b;

  // Partial remainders stay below the divisor, so 32 bits of the difference suffice.
  assign shifted = {rem_q, a_q[31]};
  assign trial   = shifted[31:0] - b_q;
  assign fits    = shifted >= {1'b0, b_q};

  assign op_signed = (bus_io.operation == OpDiv);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    rem_d        = rem_q;
    mul_signed_d = mul_signed_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    div_zero_d   = div_zero_q;
    hi_we_d      = 1'b0;
    lo_we_d      = 1'b0;
    hi_data_d    = hi_data_q;
    lo_data_d    = lo_data_q;

    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          case (bus_io.operation)
            OpMult, OpMultu: begin
              a_d          = bus_io.operand_a;
              b_d          = bus_io.operand_b;
              mul_signed_d = (bus_io.operation == OpMult);
              state_d      = StMul;
            end
            OpDiv, OpDivu: begin
              a_d        = (op_signed && bus_io.operand_a[31]) ? -bus_io.operand_a
                                                                : bus_io.operand_a;
              b_d        = (op_signed && bus_io.operand_b[31]) ? -bus_io.operand_b
                                                                : bus_io.operand_b;
              neg_quo_d  = op_signed & (bus_io.operand_a[31] ^ bus_io.operand_b[31]);
              neg_rem_d  = op_signed & bus_io.operand_a[31];
              div_zero_d = (bus_io.operand_b == 32'd0);
              rem_d      = 32'd0;
              cnt_d      = 6'd0;
              state_d    = StDiv;
            end
            OpMthi: begin
              hi_we_d   = 1'b1;
              hi_data_d = bus_io.operand_a;
            end
            OpMtlo: begin
              lo_we_d   = 1'b1;
              lo_data_d = bus_io.operand_a;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        hi_we_d   = 1'b1;
        lo_we_d   = 1'b1;
        hi_data_d = product[63:32];
        lo_data_d = product[31:0];
        state_d   = StIdle;
      end
      StDiv: begin
        rem_d = fits ? trial : shifted[31:0];
        a_d   = {a_q[30:0], fits};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_ITERATIONS - 1)) state_d = StDivFix;
      end
      StDivFix: begin
        // A zero divisor leaves |a| in the remainder, so the sign fix restores operand_a.
        hi_we_d   = 1'b1;
        lo_we_d   = 1'b1;
        hi_data_d = neg_rem_q ? -rem_q : rem_q;
        lo_data_d = div_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? -a_q : a_q);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus_io.cancel) begin
      state_d   = StIdle;
      hi_we_d   = 1'b0;
      lo_we_d   = 1'b0;
      hi_data_d = hi_data_q;
      lo_data_d = lo_data_q;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 6'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rem_q        <= 32'd0;
      mul_signed_q <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
      hi_we_q      <= 1'b0;
      lo_we_q      <= 1'b0;
      hi_data_q    <= 32'd0;
      lo_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rem_q        <= rem_d;
      mul_signed_q <= mul_signed_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      div_zero_q   <= div_zero_d;
      busy_q       <= busy_d;
      hi_we_q      <= hi_we_d;
      lo_we_q      <= lo_we_d;
      hi_data_q    <= hi_data_d;
      lo_data_q    <= lo_data_d;
    end
  end

  assign bus_io.busy                     = busy_q;
  assign bus_io.register_hi_write_enable = hi_we_q;
  assign bus_io.register_hi_write_data   = hi_data_q;
  assign bus_io.register_lo_write_enable = lo_we_q;
  assign bus_io.register_lo_write_data   = lo_data_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected write pulses,
// a negedge monitor pops and compares values and arrival cycle.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef struct {
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  hilo_muldiv_unit_if bus ();

  hilo_muldiv_unit dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every enable pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (reset === 1'b0 &&
        (bus.register_hi_write_enable === 1'b1 || bus.register_lo_write_enable === 1'b1)) begin
      if (sb.size() == 0) begin
        check("unexpected_write",
              {62'd0, bus.register_hi_write_enable, bus.register_lo_write_enable}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_we"},
              {62'd0, bus.register_hi_write_enable, bus.register_lo_write_enable},
              {62'd0, e.hwe, e.lwe});
        if (e.hwe) check({e.name, "_hi"}, {32'd0, bus.register_hi_write_data}, {32'd0, e.hi});
        if (e.lwe) check({e.name, "_lo"}, {32'd0, bus.register_lo_write_data}, {32'd0, e.lo});
        check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at posedge+1; the coming edge is the start edge k.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic hwe, input logic lwe,
                       input logic [31:0] hi, input logic [31:0] lo, input string name);
    exp_t e;
    e.hwe = hwe; e.lwe = lwe; e.hi = hi; e.lo = lo; e.cyc = cyc + 1 + lat; e.name = name;
    sb.push_back(e);
    bus.start = 1'b1; bus.operation = op; bus.operand_a = a; bus.operand_b = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.operation = 3'd0;
  endtask

  task automatic wait_idle(input int exp_n, input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b1; bus.operation = OpMthi; bus.operand_a = 32'h1234_5678;
    bus.operand_b = 32'd0; bus.cancel = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_we", {62'd0, bus.register_hi_write_enable, bus.register_lo_write_enable}, 64'd0);
    check("reset_hi", {32'd0, bus.register_hi_write_data}, 64'd0);
    check("reset_lo", {32'd0, bus.register_lo_write_data}, 64'd0);
    reset = 1'b0; bus.start = 1'b0; bus.operation = 3'd0;
    idle(1);

    issue(OpMthi, 32'h1234_5678, 32'd0, 0, 1'b1, 1'b0, 32'h1234_5678, 32'd0, "mthi");
    wait_idle(0, "mthi");
    issue(OpMtlo, 32'hCAFE_0001, 32'd0, 0, 1'b0, 1'b1, 32'd0, 32'hCAFE_0001, "mtlo");
    idle(1);

    issue(OpMult, 32'hFFFF_FFFE, 32'd3, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
    wait_idle(1, "mult");
    issue(OpMultu, 32'hFFFF_FFFE, 32'd3, 1, 1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
    wait_idle(1, "multu");

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    wait_idle(33, "div_m7_2");
    issue(OpDivu, 32'd100, 32'd7, 33, 1'b1, 1'b1, 32'd2, 32'd14, "divu_100_7");
    wait_idle(33, "divu_100_7");
    issue(OpDiv, 32'd7, 32'hFFFF_FFFE, 33, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFD, "div_7_m2");
    wait_idle(33, "div_7_m2");
    issue(OpDivu, 32'h55, 32'd0, 33, 1'b1, 1'b1, 32'h55, 32'hFFFF_FFFF, "divu_by0");
    wait_idle(33, "divu_by0");
    issue(OpDiv, 32'hFFFF_FF00, 32'd0, 33, 1'b1, 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div_by0");
    wait_idle(33, "div_by0");
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, 1'b1, 32'd0, 32'h8000_0000, "div_ovf");
    wait_idle(33, "div_ovf");

    // MTLO presented mid-divide must be dropped.
    issue(OpDiv, 32'd20, 32'd3, 33, 1'b1, 1'b1, 32'd2, 32'd6, "div_mid_mtlo");
    idle(5);
    bus.start = 1'b1; bus.operation = OpMtlo; bus.operand_a = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.operation = 3'd0;
    wait_idle(27, "div_mid_mtlo");

    // Cancel at edge k+10: no result.
    bus.start = 1'b1; bus.operation = OpDiv; bus.operand_a = 32'd50; bus.operand_b = 32'd5;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.operation = 3'd0;
    idle(9);
    bus.cancel = 1'b1;
    @(posedge clock); #1;
    bus.cancel = 1'b0;
    check("cancel_mid_busy", {63'd0, bus.busy}, 64'd0);
    idle(40);
    issue(OpMthi, 32'hA5A5_0F0F, 32'd0, 0, 1'b1, 1'b0, 32'hA5A5_0F0F, 32'd0, "mthi_after_cancel");
    idle(1);

    // Cancel exactly on the completion edge k+33.
    bus.start = 1'b1; bus.operation = OpDivu; bus.operand_a = 32'd9; bus.operand_b = 32'd4;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.operation = 3'd0;
    idle(32);
    check("cancel_end_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.cancel = 1'b1;
    @(posedge clock); #1;
    bus.cancel = 1'b0;
    check("cancel_end_busy", {63'd0, bus.busy}, 64'd0);
    idle(3);

    // Cancel in IDLE blocks MTLO.
    bus.start = 1'b1; bus.operation = OpMtlo; bus.operand_a = 32'h1111_2222; bus.cancel = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.operation = 3'd0; bus.cancel = 1'b0;
    idle(3);
    check("lo_held_after_blocked_mtlo", {32'd0, bus.register_lo_write_data}, {32'd0, 32'd6});

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
